// File: rtl/ctrl_data_fifo.sv
// Paired data/ctrl FIFO: two independently filled queues, popped together as one {ctrl, data} entry.
// The popped pair reaches dout READ_LATENCY cycles after the pop and is held until consumed.
module ctrl_data_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int CTRL_WIDTH   = 8,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH-1:0]          din_data,
    input  logic                           data_valid,
    output logic                           data_ready,
    input  logic [CTRL_WIDTH-1:0]          ctrl_data,
    input  logic                           ctrl_valid,
    output logic                           ctrl_ready,
    output logic [CTRL_WIDTH+DATA_WIDTH-1:0] dout,
    output logic                           valid,
    input  logic                           ready,
    input  logic                           shift_out,
    output logic                           empty,
    output logic                           data_overflow,
    output logic                           data_underflow,
    output logic                           ctrl_overflow,
    output logic                           ctrl_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int OW = CTRL_WIDTH + DATA_WIDTH;

    logic [PW-1:0]         data_wr_ptr, data_rd_ptr;
    logic [PW-1:0]         ctrl_wr_ptr, ctrl_rd_ptr;
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [CTRL_WIDTH-1:0] ctrl_mem [DEPTH];

    logic data_full, data_empty, ctrl_full, ctrl_empty;
    logic data_push, ctrl_push, pop;
    logic [OW-1:0] rd_pair;

    logic [OW-1:0] pair_p0;
    logic          vld_p0;
    logic [OW-1:0] pair_p1;
    logic          vld_p1;
    logic [OW-1:0] land_pair;
    logic          land_vld;

    // Full when the index bits match but the wrap bits differ.
    assign data_empty = (data_wr_ptr == data_rd_ptr);
    assign ctrl_empty = (ctrl_wr_ptr == ctrl_rd_ptr);
    assign data_full  = (data_wr_ptr[AW] != data_rd_ptr[AW]) &&
                        (data_wr_ptr[AW-1:0] == data_rd_ptr[AW-1:0]);
    assign ctrl_full  = (ctrl_wr_ptr[AW] != ctrl_rd_ptr[AW]) &&
                        (ctrl_wr_ptr[AW-1:0] == ctrl_rd_ptr[AW-1:0]);

    assign data_ready = !data_full;
    assign ctrl_ready = !ctrl_full;
    assign empty      = data_empty || ctrl_empty;

    assign data_push = data_valid && !data_full;
    assign ctrl_push = ctrl_valid && !ctrl_full;
    assign pop       = shift_out && !empty;

    assign rd_pair = {ctrl_mem[ctrl_rd_ptr[AW-1:0]], data_mem[data_rd_ptr[AW-1:0]]};

    always_ff @(posedge clk) begin
        if (data_push) data_mem[data_wr_ptr[AW-1:0]] <= din_data;
        if (ctrl_push) ctrl_mem[ctrl_wr_ptr[AW-1:0]] <= ctrl_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_wr_ptr <= '0;
            data_rd_ptr <= '0;
            ctrl_wr_ptr <= '0;
            ctrl_rd_ptr <= '0;
        end else begin
            if (data_push) data_wr_ptr <= data_wr_ptr + 1'b1;
            if (ctrl_push) ctrl_wr_ptr <= ctrl_wr_ptr + 1'b1;
            if (pop) begin
                data_rd_ptr <= data_rd_ptr + 1'b1;
                ctrl_rd_ptr <= ctrl_rd_ptr + 1'b1;
            end
        end
    end

    // Stage p0: registered read of the popped pair (used only when two stages are configured).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= pop;
            if (pop) pair_p0 <= rd_pair;
        end
    end

    assign land_vld  = (READ_LATENCY == 1) ? pop     : vld_p0;
    assign land_pair = (READ_LATENCY == 1) ? rd_pair : pair_p0;

    // Stage p1: output holding register; a landing pair always replaces the held one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            if (land_vld) begin
                pair_p1 <= land_pair;
                vld_p1  <= 1'b1;
            end else if (vld_p1 && ready) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign dout  = pair_p1;
    assign valid = vld_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_overflow  <= 1'b0;
            ctrl_overflow  <= 1'b0;
            data_underflow <= 1'b0;
            ctrl_underflow <= 1'b0;
        end else begin
            data_overflow  <= data_valid && data_full;
            ctrl_overflow  <= ctrl_valid && ctrl_full;
            data_underflow <= shift_out && data_empty;
            ctrl_underflow <= shift_out && ctrl_empty;
        end
    end

endmodule

// File: tb/tb_ctrl_data_fifo.sv
// Bench for ctrl_data_fifo: directed test-plan steps followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_ctrl_data_fifo;

    localparam int DW    = 32;
    localparam int CW    = 8;
    localparam int DEPTH = 16;
    localparam int RL    = 1;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] din_data;
    logic          data_valid;
    logic          data_ready;
    logic [CW-1:0] ctrl_data;
    logic          ctrl_valid;
    logic          ctrl_ready;
    logic [CW+DW-1:0] dout;
    logic          valid;
    logic          ready;
    logic          shift_out;
    logic          empty;
    logic          data_overflow;
    logic          data_underflow;
    logic          ctrl_overflow;
    logic          ctrl_underflow;

    int tests = 0;
    int fails = 0;

    ctrl_data_fifo #(
        .DATA_WIDTH  (DW),
        .CTRL_WIDTH  (CW),
        .DEPTH       (DEPTH),
        .READ_LATENCY(RL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .din_data      (din_data),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .ctrl_data     (ctrl_data),
        .ctrl_valid    (ctrl_valid),
        .ctrl_ready    (ctrl_ready),
        .dout          (dout),
        .valid         (valid),
        .ready         (ready),
        .shift_out     (shift_out),
        .empty         (empty),
        .data_overflow (data_overflow),
        .data_underflow(data_underflow),
        .ctrl_overflow (ctrl_overflow),
        .ctrl_underflow(ctrl_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: two plain queues plus the output slot and error pulses.
    logic [DW-1:0]    dq[$];
    logic [CW-1:0]    cq[$];
    logic [CW+DW-1:0] m_dout;
    logic             m_valid;
    logic             m_dovf, m_covf, m_dunf, m_cunf;

    task automatic model_reset();
        dq.delete();
        cq.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_dovf  = 1'b0;
        m_covf  = 1'b0;
        m_dunf  = 1'b0;
        m_cunf  = 1'b0;
    endtask

    task automatic model_edge();
        bit dfull, cfull, dmt, cmt, take;
        logic [DW-1:0] dw;
        logic [CW-1:0] cw;
        if (!rst_n) return;
        dfull = (dq.size() == DEPTH);
        cfull = (cq.size() == DEPTH);
        dmt   = (dq.size() == 0);
        cmt   = (cq.size() == 0);
        take  = shift_out && !dmt && !cmt;
        m_dovf = data_valid && dfull;
        m_covf = ctrl_valid && cfull;
        m_dunf = shift_out && dmt;
        m_cunf = shift_out && cmt;
        if (take) begin
            dw = dq.pop_front();
            cw = cq.pop_front();
            m_dout  = {cw, dw};
            m_valid = 1'b1;
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
        if (data_valid && !dfull) dq.push_back(din_data);
        if (ctrl_valid && !cfull) cq.push_back(ctrl_data);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid", {63'd0, valid}, {63'd0, m_valid});
        chk("dout", {24'd0, dout}, {24'd0, m_dout});
        chk("empty", {63'd0, empty}, {63'd0, (dq.size() == 0 || cq.size() == 0)});
        chk("data_ready", {63'd0, data_ready}, {63'd0, (dq.size() < DEPTH)});
        chk("ctrl_ready", {63'd0, ctrl_ready}, {63'd0, (cq.size() < DEPTH)});
        chk("data_overflow", {63'd0, data_overflow}, {63'd0, m_dovf});
        chk("ctrl_overflow", {63'd0, ctrl_overflow}, {63'd0, m_covf});
        chk("data_underflow", {63'd0, data_underflow}, {63'd0, m_dunf});
        chk("ctrl_underflow", {63'd0, ctrl_underflow}, {63'd0, m_cunf});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        data_valid = 1'b0;
        ctrl_valid = 1'b0;
        shift_out  = 1'b0;
        din_data   = '0;
        ctrl_data  = '0;
    endtask

    logic [DW-1:0] dv[3];
    logic [CW-1:0] cv[3];

    initial begin
        rst_n = 1'b1;
        ready = 1'b1;
        idle();
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous data/ctrl push, then a single pop.
        data_valid = 1'b1; din_data = 32'hA5A5A5A5;
        ctrl_valid = 1'b1; ctrl_data = 8'h12;
        step();
        chk("empty_after_pair", {63'd0, empty}, 64'd0);
        idle(); shift_out = 1'b1; ready = 1'b1;
        step();
        chk("first_pair", {24'd0, dout}, 64'h12A5A5A5A5);
        chk("first_valid", {63'd0, valid}, 64'd1);
        idle();
        step();

        // Data runs ahead of ctrl; pairs form only once ctrl arrives.
        for (int i = 0; i < 3; i++) begin
            dv[i] = $urandom; cv[i] = 8'($urandom);
            data_valid = 1'b1; din_data = dv[i];
            step();
        end
        idle();
        chk("empty_data_only", {63'd0, empty}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            ctrl_valid = 1'b1; ctrl_data = cv[i];
            step();
        end
        idle();
        chk("empty_paired", {63'd0, empty}, 64'd0);
        shift_out = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b2b_pair", {24'd0, dout}, {24'd0, cv[i], dv[i]});
            chk("b2b_valid", {63'd0, valid}, 64'd1);
        end
        idle();
        step();

        // Fill the data queue, overflow once, then drain across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) begin
            data_valid = 1'b1; din_data = $urandom;
            step();
        end
        chk("data_full_ready", {63'd0, data_ready}, 64'd0);
        din_data = 32'hDEADBEEF;
        step();
        chk("data_overflow_pulse", {63'd0, data_overflow}, 64'd1);
        idle();
        step();
        chk("data_overflow_clear", {63'd0, data_overflow}, 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            ctrl_valid = 1'b1; ctrl_data = 8'($urandom);
            step();
        end
        idle(); shift_out = 1'b1;
        for (int i = 0; i < DEPTH; i++) step();
        idle();
        step();
        chk("drained_empty", {63'd0, empty}, 64'd1);

        // Pop with data present but no ctrl.
        data_valid = 1'b1; din_data = 32'h0BADF00D;
        step();
        idle(); shift_out = 1'b1;
        step();
        chk("ctrl_underflow_pulse", {63'd0, ctrl_underflow}, 64'd1);
        chk("underflow_no_valid", {63'd0, valid}, 64'd0);
        idle();
        step();

        // Hold with ready low, then a one-cycle ready.
        ctrl_valid = 1'b1; ctrl_data = 8'h5C;
        step();
        idle(); shift_out = 1'b1; ready = 1'b0;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held_pair", {24'd0, dout}, 64'h5C0BADF00D);
        end
        ready = 1'b1;
        step();
        chk("consumed_valid", {63'd0, valid}, 64'd0);
        ready = 1'b0;

        // Reset mid-stream with a pending output and queued entries.
        for (int i = 0; i < 4; i++) begin
            data_valid = 1'b1; din_data = $urandom;
            ctrl_valid = 1'b1; ctrl_data = 8'($urandom);
            shift_out = (i == 3);
            step();
        end
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_empty", {63'd0, empty}, 64'd1);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            data_valid = ($urandom_range(0, 99) < 55);
            din_data   = $urandom;
            ctrl_valid = ($urandom_range(0, 99) < 55);
            ctrl_data  = 8'($urandom);
            shift_out  = ($urandom_range(0, 99) < 45);
            ready      = ($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ctrl_data_fifo.md
Name: ctrl_data_fifo

Overview:
- Dual-queue FIFO that pairs independently handshaked data words and control words (e.g. address) into one combined output entry.
- Used by bus adapters that buffer AXI-Lite write data/address channels before forwarding {addr, data} to a simple-port master.
- Output pops are explicitly commanded via shift_out; read data appears READ_LATENCY cycles later with a valid flag.

Parameters:
- DATA_WIDTH, 32, width of data queue words.
- CTRL_WIDTH, 8, width of ctrl queue words.
- DEPTH, 256, entries per queue; power of two, >=2.
- READ_LATENCY, 1, cycles from accepted pop to dout/valid; legal values 1 or 2.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- din_data  in  DATA_WIDTH  data word to enqueue.
- data_valid  in  1  data push request.
- data_ready  out  1  data queue not full.
- ctrl_data  in  CTRL_WIDTH  ctrl word to enqueue.
- ctrl_valid  in  1  ctrl push request.
- ctrl_ready  out  1  ctrl queue not full.
- dout  out  CTRL_WIDTH+DATA_WIDTH  {ctrl, data} popped pair; ctrl in MSBs.
- valid  out  1  dout holds an unconsumed popped pair.
- ready  in  1  downstream consumes dout when valid.
- shift_out  in  1  pop command.
- empty  out  1  no complete pair available (either queue empty).
- data_overflow  out  1  push attempted on full data queue.
- data_underflow  out  1  pop attempted with data queue empty.
- ctrl_overflow  out  1  push attempted on full ctrl queue.
- ctrl_underflow  out  1  pop attempted with ctrl queue empty.

Behaviour:
- Two circular queues with read/write pointers of $clog2(DEPTH)+1 bits each; MSB distinguishes full from empty on wrap.
- Data push: data_valid && data_ready. Ctrl push: ctrl_valid && ctrl_ready. The two are independent, so either may run ahead of the other by up to DEPTH.
- data_ready = !data_full; ctrl_ready = !ctrl_full. Both are combinational from pointers with no lookahead: a push is refused when full even if a pop occurs in the same cycle.
- empty = data_empty || ctrl_empty.
- Pop: shift_out && !empty advances both read pointers together. A shift_out while empty pops nothing.
- Pop data path: the popped pair is captured through READ_LATENCY register stages.
  - dout updates and valid=1 exactly READ_LATENCY cycles after the accepted pop.
- Valid/hold rules:
  - valid stays 1 and dout is held while ready=0.
  - valid clears on the cycle after valid && ready, unless a new pair lands in that same cycle; then dout is replaced and valid stays 1.
  - Back-to-back pops give one pair per cycle.
- Simultaneous push and pop on the same queue: both take effect; occupancy is unchanged.
- Error flags are registered single-cycle pulses, asserted the cycle after the event:
  - data_overflow: data_valid && data_full.
  - ctrl_overflow: ctrl_valid && ctrl_full.
  - data_underflow: shift_out && data_empty.
  - ctrl_underflow: shift_out && ctrl_empty.
  - Overflowed pushes are dropped; queue contents are unaffected.
- Reset (async assert, sync release): pointers=0, valid=0, dout=0, all flags=0, pipeline stages cleared. Hence empty=1, data_ready=1, ctrl_ready=1.
  - Reset mid-operation discards all queued and in-flight entries; no valid appears after reset until a new pop.
- Storage may be inferred RAM (registered read) or flops; no reset required on storage array.

Test Plan:
- Reset, then push data 0xA5A5A5A5 and ctrl 0x12 in the same cycle; empty deasserts the next cycle. Pulse shift_out with ready=1 -> after 1 cycle, valid=1 and dout={0x12,0xA5A5A5A5}; empty=1 afterwards.
- Push 3 data words (D0..D2) and no ctrl -> empty stays 1. Then push ctrl C0..C2 -> empty=0. Three consecutive pops -> dout sequence {C0,D0},{C1,D1},{C2,D2} on consecutive cycles, valid high for 3 cycles.
- Fill data queue to DEPTH -> data_ready=0. One more data_valid -> data_overflow pulses 1 cycle later, contents unchanged. Drain DEPTH pairs -> order preserved across pointer wrap.
- shift_out while ctrl queue empty (data non-empty) -> ctrl_underflow pulses, no pointer moves, valid stays 0.
- Pop with ready=0 -> valid=1 and dout held for multiple cycles; raising ready for one cycle -> valid=0 the next cycle.
- Assert rst_n=0 mid-stream with valid=1 and queued entries -> valid=0, empty=1, both readys=1 immediately; no stale data afterwards.
